// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: one-deep stereo holding register, MSB-first shift-out with the
// standard one-bit delay, timed from an externally divided sclk/lrclk sampled in the mclk domain.
module i2s_tx_serializer #(
    parameter int DATA_W    = 24,
    parameter int SLOT_BITS = 32
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              lrclk,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sdout,
    output logic              underrun,
    output logic              busy
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    if (DATA_W > SLOT_BITS - 1) begin : g_cfg_check
        $error("DATA_W must not exceed SLOT_BITS-1");
    end

    // IDLE: waiting for first frame | DELAY: delay bit out, word not yet started
    // SHIFT: data bits going out    | PAD: zero fill until next slot start
    typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} state_t;

    state_t            state_q, state_d;
    logic              sclk_q;
    logic              lr_fe_q;
    logic              fe, ss, frame_start, accept;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_l_q, hold_r_q;
    logic [DATA_W-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, word;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sdout_q, sdout_d;
    logic              underrun_q, underrun_d;

    // lrclk moves together with the sclk fall, so the raw level is the new slot's value
    assign fe          = sclk_q & ~sclk;
    assign ss          = fe & (lrclk != lr_fe_q);
    assign frame_start = ss & ~lrclk;
    assign accept      = in_valid & ~hold_full_q;

    always_ff @(posedge mclk) begin
        sclk_q <= sclk;
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q     <= IDLE;
            lr_fe_q     <= 1'b0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            act_l_q     <= '0;
            act_r_q     <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            sdout_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            act_l_q     <= act_l_d;
            act_r_q     <= act_r_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            sdout_q     <= sdout_d;
            underrun_q  <= underrun_d;
            if (fe) begin
                lr_fe_q <= lrclk;
            end
            if (accept) begin
                hold_l_q <= in_left;
                hold_r_q <= in_right;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        sdout_d     = sdout_q;
        act_l_d     = act_l_q;
        act_r_d     = act_r_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;
        word        = lrclk ? act_r_q : act_l_q;

        if (frame_start) begin
            if (hold_full_q) begin
                act_l_d     = hold_l_q;
                act_r_d     = hold_r_q;
                hold_full_d = 1'b0;
            end else begin
                act_l_d    = '0;
                act_r_d    = '0;
                underrun_d = 1'b1;
            end
        end
        if (accept) begin
            hold_full_d = 1'b1;
        end

        if (fe) begin
            sdout_d = 1'b0;
            // the slot-start edge itself carries the delay bit; MSB follows on the next fall
            if (frame_start || (ss && state_q != IDLE)) begin
                state_d = DELAY;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    DELAY: begin
                        sdout_d = word[DATA_W-1];
                        shreg_d = word << 1;
                        cnt_d   = CNT_W'(1);
                        state_d = (DATA_W == 1) ? PAD : SHIFT;
                    end
                    SHIFT: begin
                        sdout_d = shreg_q[DATA_W-1];
                        shreg_d = shreg_q << 1;
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_d = PAD;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end
    end

    assign in_ready = ~hold_full_q;
    assign sdout    = sdout_q;
    assign underrun = underrun_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: an on-bench divider drives sclk/lrclk; a frame-level model
// predicts every serial bit, handshake level and underrun pulse.
module tb_i2s_tx_serializer;
    localparam int DW      = 24;
    localparam int MPS     = 4;
    localparam int FRAME_M = 64 * MPS;

    logic          mclk = 1'b0;
    logic          rst, sclk, lrclk, in_valid;
    logic [DW-1:0] in_left, in_right;
    logic          in_ready, sdout, underrun, busy;

    i2s_tx_serializer #(.DATA_W(DW), .SLOT_BITS(32)) dut (
        .mclk    (mclk),
        .rst     (rst),
        .sclk    (sclk),
        .lrclk   (lrclk),
        .in_left (in_left),
        .in_right(in_right),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .sdout   (sdout),
        .underrun(underrun),
        .busy    (busy)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        bit            send;
        logic [DW-1:0] l, r, exp_l, exp_r;
        int            exp_ur;
    } vec_t;

    typedef struct {
        logic [DW-1:0] l, r;
    } pair_t;

    int checks = 0;
    int failures = 0;

    int dcnt;
    bit run, fell, moved;

    bit            m_armed, m_started, m_pend_full, m_exp_ur, m_acc;
    logic [DW-1:0] m_pend_l, m_pend_r, m_act_l, m_act_r;

    int            ur_seen, frames_done, ones_cnt, ones_l;
    logic [DW-1:0] rx, cap_l, cap_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    function automatic logic exp_bit();
        int p, b;
        logic [DW-1:0] w;
        p = (dcnt / MPS) % 64;
        b = p % 32;
        w = (p >= 32) ? m_act_r : m_act_l;
        if (!m_started || b < 1 || b > DW) return 1'b0;
        return w[DW-b];
    endfunction

    // Frame-level rules applied to the inputs that the coming mclk edge will see.
    task automatic model_pre();
        m_exp_ur = 1'b0;
        m_acc    = 1'b0;
        if (rst) begin
            m_armed = 0; m_started = 0; m_pend_full = 0;
            m_act_l = '0; m_act_r = '0; fell = 0;
            return;
        end
        m_acc = in_valid && !m_pend_full;
        if (fell) begin
            int p;
            p = (dcnt / MPS) % 64;
            if (lrclk) m_armed = 1;
            else if (p == 0 && m_armed) begin
                m_started = 1;
                if (m_pend_full) begin
                    m_act_l = m_pend_l; m_act_r = m_pend_r; m_pend_full = 0;
                end else begin
                    m_act_l = '0; m_act_r = '0; m_exp_ur = 1;
                end
            end
        end
        if (m_acc) begin
            m_pend_l = in_left; m_pend_r = in_right; m_pend_full = 1;
        end
        fell = 0;
    endtask

    task automatic tick();
        model_pre();
        @(negedge mclk);
        check("sdout", sdout, exp_bit());
        check("underrun", underrun, m_exp_ur);
        check("busy", busy, m_started);
        check("in_ready", in_ready, !m_pend_full);
        if (underrun) ur_seen++;
        if (moved && (dcnt % MPS) == 2) begin
            int p, b;
            p = (dcnt / MPS) % 64;
            b = p % 32;
            if (b >= 1 && b <= DW) rx = {rx[DW-2:0], sdout};
            if (p < 32 && sdout) ones_cnt++;
            if (b == 31) begin
                if (p < 32) begin
                    cap_l = rx; ones_l = ones_cnt; ones_cnt = 0;
                end else begin
                    cap_r = rx; frames_done++;
                end
            end
        end
        moved = run;
        if (run) begin
            dcnt++;
            if (dcnt % MPS == 0) fell = 1;
        end
        sclk  = (dcnt % MPS) >= 2;
        lrclk = ((dcnt / MPS) % 64) >= 32;
    endtask

    task automatic wait_pos(input int target);
        int n;
        n = 0;
        while ((dcnt % FRAME_M) != target && n < 2 * FRAME_M) begin
            tick();
            n++;
        end
        if ((dcnt % FRAME_M) != target) timeout("wait_pos");
    endtask

    task automatic wait_frames(input int k);
        int target, n;
        target = frames_done + k;
        n = 0;
        while (frames_done < target && n < (k + 1) * FRAME_M) begin
            tick();
            n++;
        end
        if (frames_done < target) timeout("wait_frames");
    endtask

    task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int n;
        n = 0;
        in_left = l; in_right = r; in_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 4 * FRAME_M);
        in_valid = 1'b0;
        if (!m_acc) timeout("offer");
    endtask

    vec_t  vt[6];
    pair_t sent_q[$];

    initial begin
        int ur0, fd0, seen_fd, nacc;
        pair_t pr;
        logic [DW-1:0] rl, rr;
        bit do_send;

        vt[0] = '{1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 1};
        vt[1] = '{1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 1};
        vt[2] = '{1'b1, 24'd50321, 24'd34245, 24'h00C491, 24'h0085C5, 0};
        vt[3] = '{1'b1, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000, 0};
        vt[4] = '{1'b1, 24'h800001, 24'h7FFFFE, 24'h800001, 24'h7FFFFE, 0};
        vt[5] = '{1'b0, 24'h123456, 24'h654321, 24'h0, 24'h0, 1};

        m_armed = 0; m_started = 0; m_pend_full = 0; m_act_l = '0; m_act_r = '0;
        m_pend_l = '0; m_pend_r = '0;
        ur_seen = 0; frames_done = 0; ones_cnt = 0; ones_l = 0;
        rx = '0; cap_l = '0; cap_r = '0;
        run = 1; fell = 0; moved = 0;
        dcnt = 50 * MPS + 1;
        sclk = (dcnt % MPS) >= 2;
        lrclk = ((dcnt / MPS) % 64) >= 32;
        rst = 1'b1; in_valid = 1'b0; in_left = '0; in_right = '0;

        repeat (3) tick();
        rst = 1'b0;
        check("rst_sdout", sdout, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_underrun", underrun, 1'b0);
        check("rst_busy", busy, 1'b0);

        // Directed frames
        for (int i = 0; i < 6; i++) begin
            wait_pos(40 * MPS);
            ur0 = ur_seen;
            if (vt[i].send) offer(vt[i].l, vt[i].r);
            wait_frames(2);
            check($sformatf("vec%0d_left", i), cap_l, vt[i].exp_l);
            check($sformatf("vec%0d_right", i), cap_r, vt[i].exp_r);
            check($sformatf("vec%0d_left_ones", i), ones_l, $countones(vt[i].exp_l));
            check($sformatf("vec%0d_underruns", i), ur_seen - ur0, vt[i].exp_ur);
        end

        // Back-to-back: new pair offered as soon as the previous one is taken
        wait_pos(40 * MPS);
        ur0 = ur_seen; fd0 = frames_done; seen_fd = frames_done; nacc = 0;
        in_left = DW'($urandom); in_right = DW'($urandom); in_valid = 1'b1;
        begin
            int n;
            n = 0;
            while (frames_done < fd0 + 5 && n < 6 * FRAME_M) begin
                tick();
                n++;
                if (m_acc) begin
                    pr.l = in_left; pr.r = in_right;
                    sent_q.push_back(pr);
                    nacc++;
                    in_left = DW'($urandom); in_right = DW'($urandom);
                end
                if (frames_done != seen_fd) begin
                    seen_fd = frames_done;
                    if (frames_done - fd0 >= 2) begin
                        if (sent_q.size() > 0) begin
                            pr = sent_q.pop_front();
                            check("b2b_left_order", cap_l, pr.l);
                            check("b2b_right_order", cap_r, pr.r);
                        end else timeout("b2b_queue");
                    end
                end
            end
            if (frames_done < fd0 + 5) timeout("b2b_frames");
        end
        in_valid = 1'b0;
        check("b2b_underruns", ur_seen - ur0, 0);
        check("b2b_accepts", nacc, 5);
        sent_q.delete();

        // Accept on the very edge that starts a frame with the holding register empty
        wait_pos(40 * MPS);
        wait_frames(1);
        wait_pos(0);
        in_left = 24'h3C3C3C; in_right = 24'hC3C3C3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("ss_accept_underrun", underrun, 1'b1);
        check("ss_accept_in_ready", in_ready, 1'b0);
        wait_frames(1);
        check("ss_accept_zero_left", cap_l, 24'h0);
        check("ss_accept_zero_right", cap_r, 24'h0);
        wait_frames(1);
        check("ss_accept_next_left", cap_l, 24'h3C3C3C);
        check("ss_accept_next_right", cap_r, 24'hC3C3C3);

        // sclk stall in the middle of a left word
        wait_pos(40 * MPS);
        offer(24'hA5A5A5, 24'h5A5A5A);
        wait_pos(0);
        wait_pos(6 * MPS + 2);
        run = 0;
        repeat (40) tick();
        check("stall_sdout_held", sdout, 1'b1);
        check("stall_busy", busy, 1'b1);
        run = 1;
        wait_frames(1);
        check("stall_left_word", cap_l, 24'hA5A5A5);
        check("stall_right_word", cap_r, 24'h5A5A5A);

        // Reset during bit 12 of a left word
        wait_pos(40 * MPS);
        offer(24'hFFFFFF, 24'hFFFFFF);
        wait_pos(0);
        wait_pos(13 * MPS + 2);
        check("pre_rst_bit", sdout, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_abort_sdout", sdout, 1'b0);
        check("rst_abort_busy", busy, 1'b0);
        check("rst_abort_in_ready", in_ready, 1'b1);
        ur0 = ur_seen;
        wait_frames(2);
        check("post_rst_underruns", ur_seen - ur0, 1);
        check("post_rst_left", cap_l, 24'h0);

        // Random traffic, sometimes skipping a frame
        for (int i = 0; i < 6; i++) begin
            wait_pos(MPS * $urandom_range(33, 62));
            ur0 = ur_seen;
            do_send = ($urandom_range(0, 3) != 0);
            rl = DW'($urandom); rr = DW'($urandom);
            if (do_send) offer(rl, rr);
            wait_frames(2);
            check($sformatf("rnd%0d_left", i), cap_l, do_send ? rl : 24'h0);
            check($sformatf("rnd%0d_right", i), cap_r, do_send ? rr : 24'h0);
            check($sformatf("rnd%0d_underruns", i), ur_seen - ur0, do_send ? 0 : 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
